mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, data width of both ports and memory.
REQ-002 Parameter ADDR_W, default 64, address width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles (>=1).
REQ-004 Parameter STARVE_MAX, default 4, max consecutive data grants while instruction request is pending.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 i_req  in  1  instruction-fetch read request.
REQ-008 i_addr  in  ADDR_W  fetch address.
REQ-009 i_gnt  out  1  fetch request accepted this cycle.
REQ-010 i_rvalid  out  1  one-cycle pulse, i_rdata valid.
REQ-011 i_rdata  out  DATA_W  fetch data.
REQ-012 d_req  in  1  data-port request.
REQ-013 d_we  in  1  1 = write, 0 = read.
REQ-014 d_addr  in  ADDR_W  data address.
REQ-015 d_wdata  in  DATA_W  write data.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  one-cycle pulse; read data valid or write completed.
REQ-018 d_rdata  out  DATA_W  read data; 0 for writes.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_wr  out  1  memory write strobe.
REQ-022 mem_rdata  in  DATA_W  memory read data.

Function
REQ-023 FSM states IDLE, BUSY, RESP; grant SHALL only be issued in IDLE or RESP.
REQ-024 Grant SHALL be combinational from req inputs and state; at most one of i_gnt/d_gnt high per cycle.
REQ-025 On grant, port (I/D), we, addr, wdata SHALL be captured into internal registers; FSM enters BUSY with latency counter loaded to MEM_LAT-1.
REQ-026 In BUSY, mem_addr/mem_wdata SHALL come from captured registers; mem_wr high only in the first BUSY cycle of a write; otherwise mem_addr/mem_wdata 0 and mem_wr 0.
REQ-027 Counter decrements each BUSY cycle; at 0, mem_rdata SHALL be registered into the response register and FSM goes to RESP.
REQ-028 In RESP, rvalid of the captured port SHALL pulse for exactly one cycle; rdata held until the next response for that port.
REQ-029 Latency: grant at cycle T gives rvalid at T+MEM_LAT+1; grant in RESP gives back-to-back throughput of one access per MEM_LAT+1 cycles.
REQ-030 Priority: data wins over instruction, except when d_streak == STARVE_MAX and i_req is high, in which case instruction wins.
REQ-031 d_streak SHALL increment (saturating at STARVE_MAX) on each data grant made while i_req is high; clear on instruction grant or any cycle i_req is low.
REQ-032 Requesters hold req/addr/data stable until gnt; a req dropped before gnt SHALL cause no memory access.
REQ-033 Requests in BUSY SHALL see gnt low and remain pending.
REQ-034 No request in IDLE/RESP: RESP returns to IDLE; IDLE holds.

Reset
REQ-035 reset low SHALL immediately force state IDLE, d_streak 0, counter 0, all outputs 0 including mem_wr, i_rdata, d_rdata.
REQ-036 Reset mid-access SHALL abandon it: no rvalid issued afterward; a write in progress is not retried.

Structure
REQ-037 Shared package mem_arb_pkg SHALL hold the state enum type and default parameter constants.
REQ-038 One sub-module mem_arb_pick (combinational priority/starvation pick) is permitted; FSM, counter and capture registers stay in mem_arbiter.

Verification
REQ-039 MEM_LAT=1: d_req read addr 0x10, mem returns 0xAB -> d_gnt at T, d_rvalid at T+2, d_rdata=0xAB, i_gnt never high.
REQ-040 Simultaneous i_req and d_req from IDLE -> d_gnt first; i_gnt granted in the RESP cycle of the data access.
REQ-041 d_req and i_req held high continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-042 d_we=1 addr 0x20 wdata 0x55 -> mem_wr high exactly one cycle with mem_addr=0x20, mem_wdata=0x55; d_rvalid at T+2, d_rdata=0.
REQ-043 MEM_LAT=3, back-to-back fetches at 0x0, 0x4 -> i_rvalid at T+4 and T+8.
REQ-044 reset low during BUSY of a read -> all outputs 0 next observation, no i_rvalid/d_rvalid until a new grant after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameter values for the memory arbiter.
//   arbState_t : arbiter FSM state encoding
//   arbPort_t  : which requester owns the access in flight
package mem_arb_pkg;

   localparam int DEF_DATA_W     = 64;
   localparam int DEF_ADDR_W     = 64;
   localparam int DEF_MEM_LAT    = 1;
   localparam int DEF_STARVE_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arbState_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } arbPort_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant pick between the fetch and data ports.
// Ports:
//   iReq, dReq  : pending requests
//   canGrant    : arbiter is in a state that may accept a request
//   streakFull  : data port has used up its run of grants over a waiting fetch
//   pickI/pickD : one-hot (or zero) grant decision
module mem_arb_pick (
   input  logic iReq,
   input  logic dReq,
   input  logic canGrant,
   input  logic streakFull,
   output logic pickI,
   output logic pickD
);

   // Data normally wins; a saturated streak hands one slot to the waiting fetch.
   assign pickI = canGrant & iReq & (streakFull | ~dReq);
   assign pickD = canGrant & dReq & ~(iReq & streakFull);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory
// with fixed read latency. One access in flight at a time.
// Ports:
//   clk, reset (async, active low)
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata       fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata   data port
//   mem_addr, mem_wdata, mem_wr -> memory ; mem_rdata <- memory
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing in flight, may grant
// BUSY    | access driven to memory, latency counter running
// RESP    | rvalid pulsing for the finished access, may grant the next
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STREAK_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LAT - 1);
   localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);

   arbState_t             state;
   logic [CNT_W-1:0]      latCnt;
   logic [STREAK_W-1:0]   dStreak;
   arbPort_t              capPort;
   logic                  capWe;
   logic [ADDR_W-1:0]     capAddr;
   logic [DATA_W-1:0]     capWdata;
   logic                  firstBusy;

   logic canGrant;
   logic anyGnt;

   // Gated by reset so grants are also forced low while reset is held.
   assign canGrant = reset & ((state == ST_IDLE) | (state == ST_RESP));
   assign anyGnt   = i_gnt | d_gnt;

   mem_arb_pick uPick (
      .iReq       (i_req),
      .dReq       (d_req),
      .canGrant   (canGrant),
      .streakFull (dStreak == STREAK_SAT),
      .pickI      (i_gnt),
      .pickD      (d_gnt)
   );

   assign mem_addr  = (state == ST_BUSY) ? capAddr  : '0;
   assign mem_wdata = (state == ST_BUSY) ? capWdata : '0;
   assign mem_wr    = (state == ST_BUSY) & capWe & firstBusy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         latCnt    <= '0;
         dStreak   <= '0;
         capPort   <= PORT_I;
         capWe     <= 1'b0;
         capAddr   <= '0;
         capWdata  <= '0;
         firstBusy <= 1'b0;
         i_rvalid  <= 1'b0;
         i_rdata   <= '0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;

         // Streak only counts data grants that overtook a waiting fetch.
         if (!i_req || i_gnt) begin
            dStreak <= '0;
         end else if (d_gnt && (dStreak != STREAK_SAT)) begin
            dStreak <= dStreak + STREAK_W'(1);
         end

         case (state)
            ST_IDLE, ST_RESP: begin
               if (anyGnt) begin
                  capPort   <= d_gnt ? PORT_D : PORT_I;
                  capWe     <= d_gnt & d_we;
                  capAddr   <= d_gnt ? d_addr : i_addr;
                  capWdata  <= d_gnt ? d_wdata : '0;
                  latCnt    <= CNT_LOAD;
                  firstBusy <= 1'b1;
                  state     <= ST_BUSY;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               firstBusy <= 1'b0;
               if (latCnt == '0) begin
                  state <= ST_RESP;
                  if (capPort == PORT_I) begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= mem_rdata;
                  end else begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= capWe ? '0 : mem_rdata;
                  end
               end else begin
                  latCnt <= latCnt - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
